// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Single-ported main RAM shared by three masters: the layer renderer
//   (read-only words), the sprite engine (word read/write with byte enables)
//   and the CPU (byte read/write).
//
//   Fixed priority is layer > sprite > CPU. A CPU that has waited
//   CPU_MAX_WAIT cycles jumps to the front of the queue.
//
//   Grants are combinational. The RAM returns read data one cycle after
//   the address is presented.
//
//   Ports
//     clk, reset                 clock, synchronous active-high reset
//     cpu_*                      CPU byte port: strobe/ack handshake, 8-bit read data + valid
//     l_*                        layer word read port: strobe/ack, read valid
//     s_*                        sprite word port: strobe/ack, byte enables, read valid
//     rddata                     shared 32-bit read data for the layer and sprite ports
//     bus_*                      RAM side: address, write data, byte enables, write strobe, read data
module vram_arbiter #(
  parameter int unsigned CPU_MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] cpu_addr,
  input  logic [7:0]  cpu_wrdata,
  input  logic        cpu_write,
  input  logic        cpu_strobe,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rddata,
  output logic        cpu_rddata_valid,
  input  logic [14:0] l_addr,
  input  logic        l_strobe,
  output logic        l_ack,
  output logic        l_rddata_valid,
  input  logic [14:0] s_addr,
  input  logic [31:0] s_wrdata,
  input  logic [3:0]  s_wrbytesel,
  input  logic        s_write,
  input  logic        s_strobe,
  output logic        s_ack,
  output logic        s_rddata_valid,
  output logic [31:0] rddata,
  output logic [14:0] bus_addr,
  output logic [31:0] bus_wrdata,
  output logic [3:0]  bus_wrbytesel,
  output logic        bus_write,
  input  logic [31:0] bus_rddata
);

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  logic [3:0] r_wait_cnt;
  logic       r_l_vld, r_s_vld, r_c_vld;
  logic [1:0] r_cpu_lane;
  logic       w_cpu_urgent;

  assign w_cpu_urgent = cpu_strobe && (r_wait_cnt >= MAX_WAIT);

  // Grant selection and RAM-side mux. Nothing is granted while in reset.
  always_comb begin
    cpu_ack       = 1'b0;
    l_ack         = 1'b0;
    s_ack         = 1'b0;
    bus_addr      = '0;
    bus_wrdata    = '0;
    bus_wrbytesel = '0;
    bus_write     = 1'b0;
    if (!reset) begin
      if (w_cpu_urgent)    cpu_ack = 1'b1;
      else if (l_strobe)   l_ack   = 1'b1;
      else if (s_strobe)   s_ack   = 1'b1;
      else if (cpu_strobe) cpu_ack = 1'b1;
    end
    if (l_ack) begin
      bus_addr = l_addr;
    end else if (s_ack) begin
      bus_addr      = s_addr;
      bus_wrdata    = s_wrdata;
      bus_wrbytesel = s_wrbytesel;
      bus_write     = s_write;
    end else if (cpu_ack) begin
      bus_addr      = cpu_addr[16:2];
      bus_wrdata    = {4{cpu_wrdata}};
      bus_wrbytesel = cpu_write ? (4'b0001 << cpu_addr[1:0]) : 4'b0000;
      bus_write     = cpu_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_l_vld    <= 1'b0;
      r_s_vld    <= 1'b0;
      r_c_vld    <= 1'b0;
      r_cpu_lane <= '0;
    end else begin
      if (!cpu_strobe || cpu_ack)  r_wait_cnt <= '0;
      else if (r_wait_cnt < MAX_WAIT) r_wait_cnt <= r_wait_cnt + 4'd1;
      r_l_vld <= l_ack;
      r_s_vld <= s_ack & ~s_write;
      r_c_vld <= cpu_ack & ~cpu_write;
      if (cpu_ack) r_cpu_lane <= cpu_addr[1:0];
    end
  end

  // Gating with reset kills a read that was granted in the cycle just
  // before reset asserted, so its valid pulse never appears.
  assign l_rddata_valid   = r_l_vld & ~reset;
  assign s_rddata_valid   = r_s_vld & ~reset;
  assign cpu_rddata_valid = r_c_vld & ~reset;
  assign rddata           = bus_rddata;
  assign cpu_rddata       = bus_rddata[{r_cpu_lane, 3'b000} +: 8];

endmodule
